// File: rtl/axi_lite_decoder_nslave.sv
// Purpose : single-master to NUM_SLAVES AXI4-Lite address router with a base/mask map,
//           an unmapped-address default responder, per-engine watchdog and error counters.
// Latency : read/write hit = 3 cycles from master handshake to master rvalid/bvalid with
//           zero-wait slaves; a decode miss answers 1 cycle after the handshake.
// Backpressure: one outstanding transaction per engine; the master ar/aw/w channels are
//           refused until the previous response has been taken (rvalid&rready, bvalid&bready).
// Ports   : clk/reset (async, active-high); i_m_axi_* / o_m_axi_* master side (no resp codes);
//           o_s_axi_* shared address/data broadcast plus one-hot per-slave strobes,
//           i_s_axi_* per-slave readies/valids and flattened read data;
//           o_decerr_cnt / o_timeout_cnt saturating counters, o_err_pulse single-cycle flag.
module axi_lite_decoder_nslave #(
    parameter int NUM_SLAVES     = 4,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_BASE =
        {32'h0300_0000, 32'h0200_0000, 32'h0100_0000, 32'h0000_0000},
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_MASK = {NUM_SLAVES{32'hFF00_0000}},
    parameter logic [DATA_WIDTH-1:0] DEFAULT_RDATA = 32'hDEAD_BEEF,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    // master write address / data / response
    input  logic                      i_m_axi_awvalid,
    output logic                      o_m_axi_awready,
    input  logic [ADDR_WIDTH-1:0]     i_m_axi_awaddr,
    input  logic [2:0]                i_m_axi_awprot,
    input  logic                      i_m_axi_wvalid,
    output logic                      o_m_axi_wready,
    input  logic [DATA_WIDTH-1:0]     i_m_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0]   i_m_axi_wstrb,
    output logic                      o_m_axi_bvalid,
    input  logic                      i_m_axi_bready,
    // master read address / data
    input  logic                      i_m_axi_arvalid,
    output logic                      o_m_axi_arready,
    input  logic [ADDR_WIDTH-1:0]     i_m_axi_araddr,
    input  logic [2:0]                i_m_axi_arprot,
    output logic                      o_m_axi_rvalid,
    input  logic                      i_m_axi_rready,
    output logic [DATA_WIDTH-1:0]     o_m_axi_rdata,
    // slave side, shared payload
    output logic [ADDR_WIDTH-1:0]     o_s_axi_awaddr,
    output logic [2:0]                o_s_axi_awprot,
    output logic [DATA_WIDTH-1:0]     o_s_axi_wdata,
    output logic [DATA_WIDTH/8-1:0]   o_s_axi_wstrb,
    output logic [ADDR_WIDTH-1:0]     o_s_axi_araddr,
    output logic [2:0]                o_s_axi_arprot,
    // slave side, per-slave strobes
    output logic [NUM_SLAVES-1:0]     o_s_axi_awvalid,
    output logic [NUM_SLAVES-1:0]     o_s_axi_wvalid,
    output logic [NUM_SLAVES-1:0]     o_s_axi_bready,
    output logic [NUM_SLAVES-1:0]     o_s_axi_arvalid,
    output logic [NUM_SLAVES-1:0]     o_s_axi_rready,
    input  logic [NUM_SLAVES-1:0]     i_s_axi_awready,
    input  logic [NUM_SLAVES-1:0]     i_s_axi_wready,
    input  logic [NUM_SLAVES-1:0]     i_s_axi_bvalid,
    input  logic [NUM_SLAVES-1:0]     i_s_axi_arready,
    input  logic [NUM_SLAVES-1:0]     i_s_axi_rvalid,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0] i_s_axi_rdata,
    // status
    output logic [CNT_WIDTH-1:0]      o_decerr_cnt,
    output logic [CNT_WIDTH-1:0]      o_timeout_cnt,
    output logic                      o_err_pulse
);

    localparam int SEL_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    // watchdog only has to reach TIMEOUT_CYCLES-1: expiry is seen on the last counted cycle
    localparam int WD_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WD_W-1:0] WD_LIM = WD_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [WD_W-1:0] WD_ONE = WD_W'(1);

    typedef enum logic [1:0] {R_IDLE, R_REQ, R_WAIT, R_RESP} rd_state_t;
    typedef enum logic [1:0] {W_IDLE, W_REQ, W_WAIT, W_RESP} wr_state_t;

    // returns {hit, index}; scanning downwards makes the lowest matching index win
    function automatic logic [SEL_W:0] f_decode(input logic [ADDR_WIDTH-1:0] addr);
        logic [SEL_W:0]      res;
        logic [ADDR_WIDTH-1:0] m;
        res = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            m = SLAVE_MASK[i*ADDR_WIDTH +: ADDR_WIDTH];
            if ((addr & m) == (SLAVE_BASE[i*ADDR_WIDTH +: ADDR_WIDTH] & m))
                res = {1'b1, SEL_W'(i)};
        end
        return res;
    endfunction

    function automatic logic [NUM_SLAVES-1:0] f_onehot(input logic [SEL_W-1:0] idx);
        logic [NUM_SLAVES-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    function automatic logic [CNT_WIDTH-1:0] f_sat_add(input logic [CNT_WIDTH-1:0] a,
                                                       input logic [1:0] inc);
        logic [CNT_WIDTH:0] s;
        s = {1'b0, a} + {{(CNT_WIDTH-1){1'b0}}, inc};
        return s[CNT_WIDTH] ? {CNT_WIDTH{1'b1}} : s[CNT_WIDTH-1:0];
    endfunction

    // ------------------------------------------------------------------ read engine
    rd_state_t          r_rd_state, w_rd_next;
    logic [SEL_W-1:0]   r_rd_sel, w_rd_sel_n;
    logic [WD_W-1:0]    r_rd_wdog;
    logic [SEL_W:0]     w_ar_dec;
    logic               w_ar_hs, w_rd_to, w_rd_miss, w_rd_tout, w_rd_ld_dflt, w_rd_ld_slv;

    assign o_m_axi_arready = ~reset & (r_rd_state == R_IDLE);
    assign w_ar_hs    = o_m_axi_arready & i_m_axi_arvalid;
    assign w_ar_dec   = f_decode(i_m_axi_araddr);
    assign w_rd_sel_n = w_ar_hs ? w_ar_dec[SEL_W-1:0] : r_rd_sel;
    assign w_rd_to    = (TIMEOUT_CYCLES != 0) && (r_rd_wdog == WD_LIM) &&
                        ((r_rd_state == R_REQ) || (r_rd_state == R_WAIT));

    always_comb begin
        w_rd_next    = r_rd_state;
        w_rd_miss    = 1'b0;
        w_rd_tout    = 1'b0;
        w_rd_ld_dflt = 1'b0;
        w_rd_ld_slv  = 1'b0;
        case (r_rd_state)
            R_IDLE: if (w_ar_hs) begin
                if (w_ar_dec[SEL_W]) begin
                    w_rd_next = R_REQ;
                end else begin
                    w_rd_next    = R_RESP;
                    w_rd_miss    = 1'b1;
                    w_rd_ld_dflt = 1'b1;
                end
            end
            R_REQ: begin
                if (w_rd_to) begin
                    w_rd_next    = R_RESP;
                    w_rd_tout    = 1'b1;
                    w_rd_ld_dflt = 1'b1;
                end else if (i_s_axi_arready[r_rd_sel]) begin
                    w_rd_next = R_WAIT;
                end
            end
            R_WAIT: begin
                // real data arriving on the expiry cycle still wins over the default
                if (i_s_axi_rvalid[r_rd_sel]) begin
                    w_rd_next   = R_RESP;
                    w_rd_ld_slv = 1'b1;
                end else if (w_rd_to) begin
                    w_rd_next    = R_RESP;
                    w_rd_tout    = 1'b1;
                    w_rd_ld_dflt = 1'b1;
                end
            end
            R_RESP: if (i_m_axi_rready) w_rd_next = R_IDLE;
            default: w_rd_next = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_state      <= R_IDLE;
            r_rd_sel        <= '0;
            r_rd_wdog       <= '0;
            o_s_axi_arvalid <= '0;
            o_s_axi_rready  <= '0;
            o_m_axi_rvalid  <= 1'b0;
            o_m_axi_rdata   <= '0;
            o_s_axi_araddr  <= '0;
            o_s_axi_arprot  <= '0;
        end else begin
            r_rd_state      <= w_rd_next;
            r_rd_sel        <= w_rd_sel_n;
            r_rd_wdog       <= ((r_rd_state == R_REQ) || (r_rd_state == R_WAIT)) ?
                               r_rd_wdog + WD_ONE : '0;
            // strobes are registered from the next state so they align with it
            o_s_axi_arvalid <= (w_rd_next == R_REQ)  ? f_onehot(w_rd_sel_n) : '0;
            o_s_axi_rready  <= (w_rd_next == R_WAIT) ? f_onehot(w_rd_sel_n) : '0;
            o_m_axi_rvalid  <= (w_rd_next == R_RESP);
            if (w_ar_hs) begin
                o_s_axi_araddr <= i_m_axi_araddr;
                o_s_axi_arprot <= i_m_axi_arprot;
            end
            if (w_rd_ld_dflt)
                o_m_axi_rdata <= DEFAULT_RDATA;
            else if (w_rd_ld_slv)
                o_m_axi_rdata <= i_s_axi_rdata[r_rd_sel*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // ----------------------------------------------------------------- write engine
    wr_state_t          r_wr_state, w_wr_next;
    logic [SEL_W-1:0]   r_wr_sel, w_wr_sel_n;
    logic [WD_W-1:0]    r_wr_wdog;
    logic [SEL_W:0]     w_aw_dec;
    logic               w_wr_acc, w_wr_to, w_wr_miss, w_wr_tout;
    logic               r_aw_done, r_w_done, w_aw_done_n, w_w_done_n;

    // address and data are only taken together, so one handshake covers both channels
    assign w_wr_acc        = ~reset & (r_wr_state == W_IDLE) & i_m_axi_awvalid & i_m_axi_wvalid;
    assign o_m_axi_awready = w_wr_acc;
    assign o_m_axi_wready  = w_wr_acc;
    assign w_aw_dec   = f_decode(i_m_axi_awaddr);
    assign w_wr_sel_n = w_wr_acc ? w_aw_dec[SEL_W-1:0] : r_wr_sel;
    assign w_wr_to    = (TIMEOUT_CYCLES != 0) && (r_wr_wdog == WD_LIM) &&
                        ((r_wr_state == W_REQ) || (r_wr_state == W_WAIT));

    always_comb begin
        w_wr_next   = r_wr_state;
        w_wr_miss   = 1'b0;
        w_wr_tout   = 1'b0;
        w_aw_done_n = 1'b0;
        w_w_done_n  = 1'b0;
        case (r_wr_state)
            W_IDLE: if (w_wr_acc) begin
                if (w_aw_dec[SEL_W]) begin
                    w_wr_next = W_REQ;
                end else begin
                    w_wr_next = W_RESP;
                    w_wr_miss = 1'b1;
                end
            end
            W_REQ: begin
                w_aw_done_n = r_aw_done | i_s_axi_awready[r_wr_sel];
                w_w_done_n  = r_w_done  | i_s_axi_wready[r_wr_sel];
                if (w_wr_to) begin
                    w_wr_next = W_RESP;
                    w_wr_tout = 1'b1;
                end else if (w_aw_done_n && w_w_done_n) begin
                    w_wr_next = W_WAIT;
                end
            end
            W_WAIT: begin
                if (i_s_axi_bvalid[r_wr_sel]) begin
                    w_wr_next = W_RESP;
                end else if (w_wr_to) begin
                    w_wr_next = W_RESP;
                    w_wr_tout = 1'b1;
                end
            end
            W_RESP: if (i_m_axi_bready) w_wr_next = W_IDLE;
            default: w_wr_next = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_state      <= W_IDLE;
            r_wr_sel        <= '0;
            r_wr_wdog       <= '0;
            r_aw_done       <= 1'b0;
            r_w_done        <= 1'b0;
            o_s_axi_awvalid <= '0;
            o_s_axi_wvalid  <= '0;
            o_s_axi_bready  <= '0;
            o_m_axi_bvalid  <= 1'b0;
            o_s_axi_awaddr  <= '0;
            o_s_axi_awprot  <= '0;
            o_s_axi_wdata   <= '0;
            o_s_axi_wstrb   <= '0;
        end else begin
            r_wr_state      <= w_wr_next;
            r_wr_sel        <= w_wr_sel_n;
            r_wr_wdog       <= ((r_wr_state == W_REQ) || (r_wr_state == W_WAIT)) ?
                               r_wr_wdog + WD_ONE : '0;
            r_aw_done       <= (w_wr_next == W_REQ) & w_aw_done_n;
            r_w_done        <= (w_wr_next == W_REQ) & w_w_done_n;
            // each strobe falls on its own once its ready has been seen
            o_s_axi_awvalid <= (w_wr_next == W_REQ) ?
                               (f_onehot(w_wr_sel_n) & ~{NUM_SLAVES{w_aw_done_n}}) : '0;
            o_s_axi_wvalid  <= (w_wr_next == W_REQ) ?
                               (f_onehot(w_wr_sel_n) & ~{NUM_SLAVES{w_w_done_n}}) : '0;
            o_s_axi_bready  <= (w_wr_next == W_WAIT) ? f_onehot(w_wr_sel_n) : '0;
            o_m_axi_bvalid  <= (w_wr_next == W_RESP);
            // a missed write is dropped, so the slave-side payload keeps its old value
            if (w_wr_acc && w_aw_dec[SEL_W]) begin
                o_s_axi_awaddr <= i_m_axi_awaddr;
                o_s_axi_awprot <= i_m_axi_awprot;
                o_s_axi_wdata  <= i_m_axi_wdata;
                o_s_axi_wstrb  <= i_m_axi_wstrb;
            end
        end
    end

    // ----------------------------------------------------------------- error status
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            o_decerr_cnt  <= '0;
            o_timeout_cnt <= '0;
            o_err_pulse   <= 1'b0;
        end else begin
            o_decerr_cnt  <= f_sat_add(o_decerr_cnt,  {1'b0, w_rd_miss} + {1'b0, w_wr_miss});
            o_timeout_cnt <= f_sat_add(o_timeout_cnt, {1'b0, w_rd_tout} + {1'b0, w_wr_tout});
            o_err_pulse   <= w_rd_miss | w_wr_miss | w_rd_tout | w_wr_tout;
        end
    end

endmodule

// File: tb/tb_axi_lite_decoder_nslave.sv
// Purpose : directed self-checking bench for axi_lite_decoder_nslave (4 slaves, 8-cycle watchdog).
// Latency : inputs change 1 time unit after a rising edge; outputs are checked before the next edge.
// Backpressure: master ready inputs and slave readies are driven explicitly per scenario.
module tb_axi_lite_decoder_nslave;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            reset;
    logic            m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready;
    logic [AW-1:0]   m_awaddr, m_araddr;
    logic [2:0]      m_awprot, m_arprot;
    logic [DW-1:0]   m_wdata;
    logic [DW/8-1:0] m_wstrb;
    logic            m_awready, m_wready, m_bvalid, m_arready, m_rvalid;
    logic [DW-1:0]   m_rdata;
    logic [AW-1:0]   s_awaddr, s_araddr;
    logic [2:0]      s_awprot, s_arprot;
    logic [DW-1:0]   s_wdata;
    logic [DW/8-1:0] s_wstrb;
    logic [N-1:0]    s_awvalid, s_wvalid, s_bready, s_arvalid, s_rready;
    logic [N-1:0]    s_awready, s_wready, s_bvalid, s_arready, s_rvalid;
    logic [N*DW-1:0] s_rdata;
    logic [15:0]     decerr_cnt, timeout_cnt;
    logic            err_pulse;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    axi_lite_decoder_nslave #(
        .NUM_SLAVES(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(8), .CNT_WIDTH(16)
    ) dut (
        .clk(clk), .reset(reset),
        .i_m_axi_awvalid(m_awvalid), .o_m_axi_awready(m_awready),
        .i_m_axi_awaddr(m_awaddr), .i_m_axi_awprot(m_awprot),
        .i_m_axi_wvalid(m_wvalid), .o_m_axi_wready(m_wready),
        .i_m_axi_wdata(m_wdata), .i_m_axi_wstrb(m_wstrb),
        .o_m_axi_bvalid(m_bvalid), .i_m_axi_bready(m_bready),
        .i_m_axi_arvalid(m_arvalid), .o_m_axi_arready(m_arready),
        .i_m_axi_araddr(m_araddr), .i_m_axi_arprot(m_arprot),
        .o_m_axi_rvalid(m_rvalid), .i_m_axi_rready(m_rready), .o_m_axi_rdata(m_rdata),
        .o_s_axi_awaddr(s_awaddr), .o_s_axi_awprot(s_awprot),
        .o_s_axi_wdata(s_wdata), .o_s_axi_wstrb(s_wstrb),
        .o_s_axi_araddr(s_araddr), .o_s_axi_arprot(s_arprot),
        .o_s_axi_awvalid(s_awvalid), .o_s_axi_wvalid(s_wvalid), .o_s_axi_bready(s_bready),
        .o_s_axi_arvalid(s_arvalid), .o_s_axi_rready(s_rready),
        .i_s_axi_awready(s_awready), .i_s_axi_wready(s_wready), .i_s_axi_bvalid(s_bvalid),
        .i_s_axi_arready(s_arready), .i_s_axi_rvalid(s_rvalid), .i_s_axi_rdata(s_rdata),
        .o_decerr_cnt(decerr_cnt), .o_timeout_cnt(timeout_cnt), .o_err_pulse(err_pulse)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        m_awvalid = 0; m_wvalid = 0; m_bready = 0; m_arvalid = 0; m_rready = 0;
        m_awaddr = '0; m_araddr = '0; m_awprot = '0; m_arprot = '0;
        m_wdata = '0; m_wstrb = '0;
        s_awready = '0; s_wready = '0; s_bvalid = '0; s_arready = '0; s_rvalid = '0;
        s_rdata = '0;
    endtask

    task automatic test_reset;
        idle_inputs();
        reset = 1'b1;
        m_arvalid = 1'b1;
        tick(); tick();
        vectors++;
        if (m_arready !== 1'b0) begin
            miscompares++; $display("FAIL reset_arready: got %b want 0", m_arready);
        end
        m_arvalid = 1'b0;
        reset = 1'b0;
        tick();
        vectors++;
        if ({s_awvalid, s_wvalid, s_bready, s_arvalid, s_rready, m_bvalid, m_rvalid, err_pulse} !== '0) begin
            miscompares++;
            $display("FAIL reset_strobes: got %b want 0",
                     {s_awvalid, s_wvalid, s_bready, s_arvalid, s_rready, m_bvalid, m_rvalid, err_pulse});
        end
        vectors++;
        if ({m_rdata, s_awaddr, s_wdata, s_araddr, decerr_cnt, timeout_cnt} !== '0) begin
            miscompares++;
            $display("FAIL reset_data: rdata %h awaddr %h wdata %h araddr %h dec %0d to %0d, want all 0",
                     m_rdata, s_awaddr, s_wdata, s_araddr, decerr_cnt, timeout_cnt);
        end
    endtask

    task automatic test_read_hit;
        m_arvalid = 1'b1; m_araddr = 32'h0100_0010; m_arprot = 3'b010;
        #1;
        vectors++;
        if (m_arready !== 1'b1) begin
            miscompares++; $display("FAIL rd_hit_arready: got %b want 1", m_arready);
        end
        tick();                                   // cycle 1
        m_arvalid = 1'b0;
        vectors++;
        if (s_arvalid !== 4'b0010 || s_rready !== 4'b0000) begin
            miscompares++; $display("FAIL rd_hit_c1: arvalid %b rready %b want 0010 0000", s_arvalid, s_rready);
        end
        vectors++;
        if (s_araddr !== 32'h0100_0010 || s_arprot !== 3'b010) begin
            miscompares++; $display("FAIL rd_hit_addr: got %h/%b want 01000010/010", s_araddr, s_arprot);
        end
        s_arready = 4'b0010;
        tick();                                   // cycle 2
        s_arready = 4'b0000;
        vectors++;
        if (s_arvalid !== 4'b0000 || s_rready !== 4'b0010 || m_rvalid !== 1'b0) begin
            miscompares++;
            $display("FAIL rd_hit_c2: arvalid %b rready %b rvalid %b want 0000 0010 0", s_arvalid, s_rready, m_rvalid);
        end
        s_rvalid = 4'b0010;
        s_rdata[63:32] = 32'h1234_5678;
        tick();                                   // cycle 3
        s_rvalid = 4'b0000;
        vectors++;
        if (m_rvalid !== 1'b1 || m_rdata !== 32'h1234_5678 || s_rready !== 4'b0000) begin
            miscompares++;
            $display("FAIL rd_hit_c3: rvalid %b rdata %h rready %b want 1 12345678 0000", m_rvalid, m_rdata, s_rready);
        end
        m_rready = 1'b1;
        tick();
        m_rready = 1'b0;
        vectors++;
        if (m_rvalid !== 1'b0) begin
            miscompares++; $display("FAIL rd_hit_done: rvalid %b want 0", m_rvalid);
        end
    endtask

    task automatic test_write_aw_first;
        m_awvalid = 1'b1; m_wvalid = 1'b1; m_awaddr = 32'h0000_0004;
        m_wdata = 32'hA5A5_A5A5; m_wstrb = 4'b0011; m_awprot = 3'b001;
        #1;
        vectors++;
        if (m_awready !== 1'b1 || m_wready !== 1'b1) begin
            miscompares++; $display("FAIL wr_accept: awready %b wready %b want 1 1", m_awready, m_wready);
        end
        tick();                                   // cycle 1
        m_awvalid = 1'b0; m_wvalid = 1'b0;
        vectors++;
        if (s_awvalid !== 4'b0001 || s_wvalid !== 4'b0001) begin
            miscompares++; $display("FAIL wr_c1: awvalid %b wvalid %b want 0001 0001", s_awvalid, s_wvalid);
        end
        vectors++;
        if (s_awaddr !== 32'h0000_0004 || s_wdata !== 32'hA5A5_A5A5 || s_wstrb !== 4'b0011 || s_awprot !== 3'b001) begin
            miscompares++;
            $display("FAIL wr_payload: addr %h data %h strb %b prot %b want 00000004 a5a5a5a5 0011 001",
                     s_awaddr, s_wdata, s_wstrb, s_awprot);
        end
        s_awready = 4'b0001;
        tick();                                   // cycle 2
        s_awready = 4'b0000;
        vectors++;
        if (s_awvalid !== 4'b0000 || s_wvalid !== 4'b0001) begin
            miscompares++; $display("FAIL wr_aw_drop: awvalid %b wvalid %b want 0000 0001", s_awvalid, s_wvalid);
        end
        tick();                                   // cycle 3
        vectors++;
        if (s_wvalid !== 4'b0001 || s_bready !== 4'b0000) begin
            miscompares++; $display("FAIL wr_w_hold: wvalid %b bready %b want 0001 0000", s_wvalid, s_bready);
        end
        s_wready = 4'b0001;
        tick();                                   // cycle 4
        s_wready = 4'b0000;
        vectors++;
        if (s_wvalid !== 4'b0000 || s_bready !== 4'b0001 || m_bvalid !== 1'b0) begin
            miscompares++;
            $display("FAIL wr_wait: wvalid %b bready %b bvalid %b want 0000 0001 0", s_wvalid, s_bready, m_bvalid);
        end
        s_bvalid = 4'b0001;
        tick();                                   // cycle 5
        s_bvalid = 4'b0000;
        vectors++;
        if (m_bvalid !== 1'b1 || s_bready !== 4'b0000) begin
            miscompares++; $display("FAIL wr_resp: bvalid %b bready %b want 1 0000", m_bvalid, s_bready);
        end
        m_bready = 1'b1;
        tick();
        m_bready = 1'b0;
        vectors++;
        if (m_bvalid !== 1'b0) begin
            miscompares++; $display("FAIL wr_single_bvalid: bvalid %b want 0", m_bvalid);
        end
    endtask

    task automatic test_read_miss;
        m_arvalid = 1'b1; m_araddr = 32'h0500_0000;
        tick();                                   // cycle 1
        m_arvalid = 1'b0;
        vectors++;
        if (m_rvalid !== 1'b1 || m_rdata !== 32'hDEAD_BEEF) begin
            miscompares++; $display("FAIL rd_miss_resp: rvalid %b rdata %h want 1 deadbeef", m_rvalid, m_rdata);
        end
        vectors++;
        if (decerr_cnt !== 16'd1 || err_pulse !== 1'b1 || s_arvalid !== 4'b0000) begin
            miscompares++;
            $display("FAIL rd_miss_err: decerr %0d pulse %b arvalid %b want 1 1 0000", decerr_cnt, err_pulse, s_arvalid);
        end
        m_rready = 1'b1;
        tick();
        m_rready = 1'b0;
        vectors++;
        if (err_pulse !== 1'b0 || m_rvalid !== 1'b0 || decerr_cnt !== 16'd1) begin
            miscompares++;
            $display("FAIL rd_miss_after: pulse %b rvalid %b decerr %0d want 0 0 1", err_pulse, m_rvalid, decerr_cnt);
        end
    endtask

    task automatic test_timeout;
        m_arvalid = 1'b1; m_araddr = 32'h0100_0000;
        tick();                                   // cycle 1, first cycle in REQ
        m_arvalid = 1'b0;
        s_arready = 4'b0010;
        tick();                                   // cycle 2
        s_arready = 4'b0000;
        for (int c = 2; c <= 8; c++) begin
            vectors++;
            if (s_rready !== 4'b0010 || m_rvalid !== 1'b0) begin
                miscompares++;
                $display("FAIL to_waiting_c%0d: rready %b rvalid %b want 0010 0", c, s_rready, m_rvalid);
            end
            tick();
        end                                       // now cycle 9
        vectors++;
        if (m_rvalid !== 1'b1 || m_rdata !== 32'hDEAD_BEEF || s_rready !== 4'b0000) begin
            miscompares++;
            $display("FAIL to_resp: rvalid %b rdata %h rready %b want 1 deadbeef 0000", m_rvalid, m_rdata, s_rready);
        end
        vectors++;
        if (timeout_cnt !== 16'd1 || err_pulse !== 1'b1 || decerr_cnt !== 16'd1) begin
            miscompares++;
            $display("FAIL to_count: timeout %0d pulse %b decerr %0d want 1 1 1", timeout_cnt, err_pulse, decerr_cnt);
        end
        m_rready = 1'b1;
        tick();
        m_rready = 1'b0;
    endtask

    task automatic test_concurrent;
        m_arvalid = 1'b1; m_araddr = 32'h0000_0020;
        m_awvalid = 1'b1; m_wvalid = 1'b1; m_awaddr = 32'h0100_0008;
        m_wdata = 32'hCAFE_F00D; m_wstrb = 4'b1111;
        tick();                                   // cycle 1
        m_arvalid = 1'b0; m_awvalid = 1'b0; m_wvalid = 1'b0;
        vectors++;
        if (s_arvalid !== 4'b0001 || s_awvalid !== 4'b0010 || s_wvalid !== 4'b0010) begin
            miscompares++;
            $display("FAIL cc_c1: arvalid %b awvalid %b wvalid %b want 0001 0010 0010", s_arvalid, s_awvalid, s_wvalid);
        end
        s_arready = 4'b0001; s_awready = 4'b0010; s_wready = 4'b0010;
        tick();                                   // cycle 2
        s_arready = '0; s_awready = '0; s_wready = '0;
        vectors++;
        if (s_rready !== 4'b0001 || s_bready !== 4'b0010) begin
            miscompares++; $display("FAIL cc_c2: rready %b bready %b want 0001 0010", s_rready, s_bready);
        end
        s_rvalid = 4'b0001; s_rdata[31:0] = 32'h0BAD_CAFE; s_bvalid = 4'b0010;
        tick();                                   // cycle 3
        s_rvalid = '0; s_bvalid = '0; s_rdata[31:0] = 32'hFFFF_FFFF;
        vectors++;
        if (m_rvalid !== 1'b1 || m_bvalid !== 1'b1 || m_rdata !== 32'h0BAD_CAFE) begin
            miscompares++;
            $display("FAIL cc_c3: rvalid %b bvalid %b rdata %h want 1 1 0badcafe", m_rvalid, m_bvalid, m_rdata);
        end
        m_bready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            m_bready = 1'b0;
            vectors++;
            if (m_rvalid !== 1'b1 || m_rdata !== 32'h0BAD_CAFE || m_bvalid !== 1'b0) begin
                miscompares++;
                $display("FAIL cc_hold_%0d: rvalid %b rdata %h bvalid %b want 1 0badcafe 0", c, m_rvalid, m_rdata, m_bvalid);
            end
        end
        m_rready = 1'b1;
        tick();
        m_rready = 1'b0;
        vectors++;
        if (m_rvalid !== 1'b0) begin
            miscompares++; $display("FAIL cc_done: rvalid %b want 0", m_rvalid);
        end
    endtask

    task automatic test_dual_miss;
        m_arvalid = 1'b1; m_araddr = 32'h0500_0000;
        m_awvalid = 1'b1; m_wvalid = 1'b1; m_awaddr = 32'h0700_0000; m_wdata = 32'h1111_1111;
        tick();                                   // cycle 1
        m_arvalid = 1'b0; m_awvalid = 1'b0; m_wvalid = 1'b0;
        vectors++;
        if (m_rvalid !== 1'b1 || m_bvalid !== 1'b1 || s_awvalid !== 4'b0000 || s_arvalid !== 4'b0000) begin
            miscompares++;
            $display("FAIL dm_resp: rvalid %b bvalid %b awvalid %b arvalid %b want 1 1 0000 0000",
                     m_rvalid, m_bvalid, s_awvalid, s_arvalid);
        end
        vectors++;
        if (decerr_cnt !== 16'd3 || err_pulse !== 1'b1 || s_wdata !== 32'hCAFE_F00D) begin
            miscompares++;
            $display("FAIL dm_count: decerr %0d pulse %b wdata %h want 3 1 cafef00d", decerr_cnt, err_pulse, s_wdata);
        end
        m_rready = 1'b1; m_bready = 1'b1;
        tick();
        m_rready = 1'b0; m_bready = 1'b0;
        vectors++;
        if (m_rvalid !== 1'b0 || m_bvalid !== 1'b0 || err_pulse !== 1'b0) begin
            miscompares++;
            $display("FAIL dm_done: rvalid %b bvalid %b pulse %b want 0 0 0", m_rvalid, m_bvalid, err_pulse);
        end
    endtask

    task automatic test_reset_mid;
        m_awvalid = 1'b1; m_wvalid = 1'b1; m_awaddr = 32'h0200_0004; m_wdata = 32'h2222_3333;
        m_wstrb = 4'b1111;
        tick();                                   // cycle 1
        m_awvalid = 1'b0; m_wvalid = 1'b0;
        s_awready = 4'b0100; s_wready = 4'b0100;
        tick();                                   // cycle 2, W_WAIT
        s_awready = '0; s_wready = '0;
        vectors++;
        if (s_bready !== 4'b0100) begin
            miscompares++; $display("FAIL rm_wait: bready %b want 0100", s_bready);
        end
        reset = 1'b1;
        tick();
        vectors++;
        if ({s_bready, s_awvalid, s_wvalid, m_bvalid, m_rvalid, err_pulse} !== '0 ||
            {s_awaddr, s_wdata, decerr_cnt, timeout_cnt} !== '0) begin
            miscompares++;
            $display("FAIL rm_reset: bready %b bvalid %b awaddr %h wdata %h dec %0d to %0d want all 0",
                     s_bready, m_bvalid, s_awaddr, s_wdata, decerr_cnt, timeout_cnt);
        end
        reset = 1'b0;
        tick();
        vectors++;
        if (m_bvalid !== 1'b0 || s_bready !== 4'b0000) begin
            miscompares++; $display("FAIL rm_no_resp: bvalid %b bready %b want 0 0000", m_bvalid, s_bready);
        end
        m_awvalid = 1'b1; m_wvalid = 1'b1; m_awaddr = 32'h0300_0000;
        m_wdata = 32'h7777_8888; m_wstrb = 4'b1100;
        tick();                                   // cycle 1
        m_awvalid = 1'b0; m_wvalid = 1'b0;
        vectors++;
        if (s_awvalid !== 4'b1000 || s_wvalid !== 4'b1000 || s_awaddr !== 32'h0300_0000 || s_wstrb !== 4'b1100) begin
            miscompares++;
            $display("FAIL rm_new_c1: awvalid %b wvalid %b addr %h strb %b want 1000 1000 03000000 1100",
                     s_awvalid, s_wvalid, s_awaddr, s_wstrb);
        end
        s_awready = 4'b1000; s_wready = 4'b1000;
        tick();                                   // cycle 2
        s_awready = '0; s_wready = '0;
        s_bvalid = 4'b1000;
        tick();                                   // cycle 3
        s_bvalid = '0;
        vectors++;
        if (m_bvalid !== 1'b1) begin
            miscompares++; $display("FAIL rm_new_resp: bvalid %b want 1", m_bvalid);
        end
        m_bready = 1'b1;
        tick();
        m_bready = 1'b0;
        vectors++;
        if (m_bvalid !== 1'b0) begin
            miscompares++; $display("FAIL rm_new_done: bvalid %b want 0", m_bvalid);
        end
    endtask

    initial begin
        test_reset();
        test_read_hit();
        test_write_aw_first();
        test_read_miss();
        test_timeout();
        test_concurrent();
        test_dual_miss();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL sim_time_limit: run did not complete within 100000 time units");
        $fatal(1);
    end

endmodule
